boy_bus_ctrl: RTL and testbench

- Parametrised bus controller between the cpu core and the cartridge/external bus.
- Decodes a configurable high-RAM window served from internal RAM, and everything else is forwarded to the external bus.
- Adds a memory-mapped OAM DMA engine that takes over the external bus to copy a block of bytes into OAM, with CPU lock-out during the copy.
- Instantiated inside boy between cpu and the external pins.

---
 rtl/boy_bus_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_boy_bus_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/boy_bus_ctrl.sv
// Bus controller between the cpu core and the external bus: high-RAM window,
// OAM DMA register/engine, and external passthrough with CPU lock-out during DMA.
module boy_bus_ctrl #(
    parameter int          HRAM_AW  = 7,
    parameter logic [15:0] DMA_ADDR = 16'hFF46,
    parameter logic [15:0] DMA_DST  = 16'hFE00,
    parameter int          DMA_LEN  = 160,
    parameter int          DMA_CYC  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    output logic [15:0] a,
    output logic [7:0]  dout,
    input  logic [7:0]  din,
    output logic        rd,
    output logic        wr,
    output logic        cs,
    output logic        dma_active
);

    localparam int              PH_W       = $clog2(DMA_CYC);
    localparam logic [PH_W-1:0] PH_HALF    = PH_W'(DMA_CYC / 2);
    localparam logic [PH_W-1:0] PH_HALF_M1 = PH_W'(DMA_CYC / 2 - 1);
    localparam logic [PH_W-1:0] PH_LAST    = PH_W'(DMA_CYC - 1);
    localparam logic [7:0]      IDX_LAST   = 8'(DMA_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_COPY
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        idx_q, idx_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [7:0]        dma_reg_q, dma_reg_d;
    logic [15:0]       src_q, src_d;
    logic [7:0]        buf_q, buf_d;
    logic [7:0]        hram_rdata_q, hram_rdata_d;
    logic [7:0]        hram_mem [2**HRAM_AW];

    logic              hram_hit;
    logic              dma_hit;
    logic              ext_hit;
    logic              dma_wr;
    logic              hram_rd;
    logic [HRAM_AW-1:0] hram_addr;
    logic [15:0]       rd_addr;
    logic [15:0]       wr_addr;

    // Decode priority: high RAM, then the DMA register, then the external bus.
    assign hram_hit  = &cpu_a[15:HRAM_AW];
    assign dma_hit   = !hram_hit && (cpu_a == DMA_ADDR);
    assign ext_hit   = !hram_hit && !dma_hit;
    assign dma_wr    = dma_hit && cpu_wr;
    assign hram_rd   = hram_hit && cpu_rd && !cpu_wr;
    assign hram_addr = cpu_a[HRAM_AW-1:0];

    assign dma_active = (state_q != S_IDLE);
    assign rd_addr    = src_q + {8'h00, idx_q};
    assign wr_addr    = DMA_DST + {8'h00, idx_q};

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        phase_d   = phase_q;
        src_d     = src_q;
        buf_d     = buf_q;
        dma_reg_d = dma_reg_q;
        if (dma_wr) begin
            dma_reg_d = cpu_dout;
        end
        case (state_q)
            S_IDLE: begin
                if (dma_wr) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                src_d   = {dma_reg_q, 8'h00};
                idx_d   = 8'h00;
                phase_d = '0;
                state_d = dma_wr ? S_START : S_COPY;
            end
            S_COPY: begin
                // A new register write abandons the byte in flight.
                if (dma_wr) begin
                    state_d = S_START;
                end else begin
                    if (phase_q == PH_HALF_M1) begin
                        buf_d = din;
                    end
                    if (phase_q == PH_LAST) begin
                        phase_d = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = S_IDLE;
                        end else begin
                            idx_d = idx_q + 8'd1;
                        end
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            idx_q     <= 8'h00;
            phase_q   <= '0;
            dma_reg_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            phase_q   <= phase_d;
            dma_reg_q <= dma_reg_d;
        end
    end

    always_ff @(posedge clk) begin
        src_q <= src_d;
        buf_q <= buf_d;
    end

    // High RAM keeps its contents across reset and stays usable during DMA.
    always_comb begin
        hram_rdata_d = hram_rdata_q;
        if (hram_rd) begin
            hram_rdata_d = hram_mem[hram_addr];
        end
    end

    always_ff @(posedge clk) begin
        hram_rdata_q <= hram_rdata_d;
        if (hram_hit && cpu_wr) begin
            hram_mem[hram_addr] <= cpu_dout;
        end
    end

    always_comb begin
        a    = cpu_a;
        dout = 8'h00;
        rd   = 1'b0;
        wr   = 1'b0;
        case (state_q)
            S_START: begin
                a = {dma_reg_q, 8'h00};
            end
            S_COPY: begin
                if (phase_q < PH_HALF) begin
                    a  = rd_addr;
                    rd = 1'b1;
                end else begin
                    a    = wr_addr;
                    dout = buf_q;
                    wr   = 1'b1;
                end
            end
            default: begin
                if (ext_hit) begin
                    dout = cpu_dout;
                    rd   = cpu_rd;
                    wr   = cpu_wr;
                end
            end
        endcase
    end

    assign cs = rd | wr;

    always_comb begin
        cpu_din = din;
        if (hram_hit) begin
            cpu_din = hram_rdata_q;
        end else if (dma_hit) begin
            cpu_din = dma_reg_q;
        end else if (dma_active) begin
            cpu_din = 8'hFF;
        end
    end

endmodule

// File: tb/tb_boy_bus_ctrl.sv
// Directed bench for boy_bus_ctrl: reset, high RAM, passthrough, DMA copy, restart, abort.
module tb_boy_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] cpu_a = 16'h0000;
    logic [7:0]  cpu_dout = 8'h00;
    logic [7:0]  cpu_din;
    logic        cpu_rd = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [15:0] a;
    logic [7:0]  dout;
    logic [7:0]  din;
    logic        rd, wr, cs, dma_active;

    logic [7:0]  ext_mem [65536];
    int          n_checks = 0;
    int          n_fails  = 0;
    int          wr_cnt   = 0;
    int          rd_cnt   = 0;
    int          cs_err   = 0;
    int          bad_wr   = 0;
    int          saw_8000 = 0;
    logic        first_rd_pend = 1'b0;
    logic [15:0] first_rd_a = 16'h0000;

    boy_bus_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_a      (cpu_a),
        .cpu_dout   (cpu_dout),
        .cpu_din    (cpu_din),
        .cpu_rd     (cpu_rd),
        .cpu_wr     (cpu_wr),
        .a          (a),
        .dout       (dout),
        .din        (din),
        .rd         (rd),
        .wr         (wr),
        .cs         (cs),
        .dma_active (dma_active)
    );

    always #5 clk = ~clk;

    assign din = ext_mem[a];

    // External memory model and bus monitor.
    always @(posedge clk) begin
        if (rst === 1'b1 && cs !== (rd | wr)) cs_err++;
        if (wr === 1'b1) begin
            ext_mem[a] = dout;
            wr_cnt++;
            if (a == 16'h8000) saw_8000++;
            if (dma_active === 1'b1 && (a < 16'hFE00 || a > 16'hFE9F)) bad_wr++;
        end
        if (rd === 1'b1 && dma_active === 1'b1) begin
            rd_cnt++;
            if (first_rd_pend) begin
                first_rd_a = a;
                first_rd_pend = 1'b0;
            end
        end
    end

    task automatic cpu_idle();
        cpu_a = 16'h0000; cpu_dout = 8'h00; cpu_rd = 1'b0; cpu_wr = 1'b0;
    endtask

    task automatic write_dma(input logic [7:0] v);
        cpu_a = 16'hFF46; cpu_dout = v; cpu_wr = 1'b1;
        @(negedge clk);
        cpu_idle();
    endtask

    task automatic clear_oam();
        for (int i = 0; i < 160; i++) ext_mem[16'hFE00 + i] = 8'hEE;
    endtask

    task automatic test_reset();
        cpu_idle();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (dma_active !== 1'b0) begin n_fails++; $display("FAIL reset_dma_active: got %b expected 0", dma_active); end
        n_checks++;
        if ({rd, wr, cs} !== 3'b000) begin n_fails++; $display("FAIL reset_bus_idle: got rd/wr/cs=%b expected 000", {rd, wr, cs}); end
        cpu_a = 16'hFF46; cpu_rd = 1'b1;
        #1;
        n_checks++;
        if (cpu_din !== 8'h00) begin n_fails++; $display("FAIL reset_dma_reg: got %h expected 00", cpu_din); end
        n_checks++;
        if ({rd, wr, cs} !== 3'b000) begin n_fails++; $display("FAIL dma_reg_not_forwarded: got rd/wr/cs=%b expected 000", {rd, wr, cs}); end
        @(negedge clk);
        cpu_idle();
    endtask

    task automatic test_hram();
        int busy_err = 0;
        cpu_a = 16'hFF80; cpu_dout = 8'hA5; cpu_wr = 1'b1;
        #1; if ({rd, wr, cs} !== 3'b000) busy_err++;
        @(negedge clk);
        cpu_a = 16'hFFFF; cpu_dout = 8'h3C;
        #1; if ({rd, wr, cs} !== 3'b000) busy_err++;
        @(negedge clk);
        cpu_wr = 1'b0; cpu_a = 16'hFF80; cpu_rd = 1'b1;
        #1; if ({rd, wr, cs} !== 3'b000) busy_err++;
        @(negedge clk);
        n_checks++;
        if (cpu_din !== 8'hA5) begin n_fails++; $display("FAIL hram_read_ff80: got %h expected a5", cpu_din); end
        if ({rd, wr, cs} !== 3'b000) busy_err++;
        @(negedge clk);
        n_checks++;
        if (cpu_din !== 8'hA5) begin n_fails++; $display("FAIL hram_hold_ff80: got %h expected a5", cpu_din); end
        cpu_a = 16'hFFFF;
        #1; if ({rd, wr, cs} !== 3'b000) busy_err++;
        @(negedge clk);
        n_checks++;
        if (cpu_din !== 8'h3C) begin n_fails++; $display("FAIL hram_read_ffff: got %h expected 3c", cpu_din); end
        if ({rd, wr, cs} !== 3'b000) busy_err++;
        @(negedge clk);
        n_checks++;
        if (cpu_din !== 8'h3C) begin n_fails++; $display("FAIL hram_hold_ffff: got %h expected 3c", cpu_din); end
        n_checks++;
        if (busy_err != 0) begin n_fails++; $display("FAIL hram_bus_quiet: got %0d busy samples expected 0", busy_err); end
        cpu_idle();
    endtask

    task automatic test_ext();
        cpu_a = 16'h4000; cpu_rd = 1'b1;
        #1;
        n_checks++;
        if ({rd, wr, cs} !== 3'b101) begin n_fails++; $display("FAIL ext_rd_strobes: got rd/wr/cs=%b expected 101", {rd, wr, cs}); end
        n_checks++;
        if (a !== 16'h4000) begin n_fails++; $display("FAIL ext_rd_addr: got %h expected 4000", a); end
        n_checks++;
        if (cpu_din !== 8'h77) begin n_fails++; $display("FAIL ext_rd_data: got %h expected 77", cpu_din); end
        @(negedge clk);
        cpu_rd = 1'b0; cpu_a = 16'hA000; cpu_dout = 8'h12; cpu_wr = 1'b1;
        #1;
        n_checks++;
        if ({rd, wr, cs, a, dout} !== {3'b011, 16'hA000, 8'h12}) begin
            n_fails++; $display("FAIL ext_wr: got rd/wr/cs=%b a=%h dout=%h expected 011 a000 12", {rd, wr, cs}, a, dout);
        end
        cpu_wr = 1'b0;
        @(negedge clk);
        cpu_idle();
    endtask

    task automatic test_dma_default();
        int cnt = 0;
        int bad = 0;
        clear_oam();
        wr_cnt = 0; rd_cnt = 0; bad_wr = 0; saw_8000 = 0;
        write_dma(8'hC0);
        while (dma_active === 1'b1 && cnt < 2000) begin
            cnt++;
            case (cnt)
                10: begin
                    cpu_a = 16'hC000; cpu_rd = 1'b1;
                    #1;
                    n_checks++;
                    if (cpu_din !== 8'hFF) begin n_fails++; $display("FAIL dma_lockout_read: got %h expected ff", cpu_din); end
                end
                11: begin cpu_rd = 1'b0; cpu_a = 16'h8000; cpu_dout = 8'h99; cpu_wr = 1'b1; end
                12: begin cpu_a = 16'hFF90; cpu_dout = 8'h5E; cpu_wr = 1'b1; end
                13: begin cpu_wr = 1'b0; cpu_rd = 1'b1; end
                14: begin
                    #1;
                    n_checks++;
                    if (cpu_din !== 8'h5E) begin n_fails++; $display("FAIL dma_hram_access: got %h expected 5e", cpu_din); end
                    cpu_rd = 1'b0; cpu_a = 16'hFF46; cpu_rd = 1'b1;
                    #1;
                    n_checks++;
                    if (cpu_din !== 8'hC0) begin n_fails++; $display("FAIL dma_reg_readback: got %h expected c0", cpu_din); end
                    cpu_idle();
                end
                default: ;
            endcase
            @(negedge clk);
        end
        n_checks++;
        if (cnt != 641) begin n_fails++; $display("FAIL dma_duration: got %0d clocks expected 641", cnt); end
        n_checks++;
        if (wr_cnt != 320 || rd_cnt != 320) begin n_fails++; $display("FAIL dma_bus_cycles: got wr=%0d rd=%0d expected 320 320", wr_cnt, rd_cnt); end
        n_checks++;
        if (bad_wr != 0 || saw_8000 != 0) begin n_fails++; $display("FAIL dma_stray_writes: got stray=%0d cpu8000=%0d expected 0 0", bad_wr, saw_8000); end
        for (int i = 0; i < 160; i++) if (ext_mem[16'hFE00 + i] !== 8'(i)) bad++;
        n_checks++;
        if (bad != 0) begin n_fails++; $display("FAIL dma_oam_data: got %0d wrong bytes expected 0", bad); end
        n_checks++;
        if ({rd, wr, cs} !== 3'b000) begin n_fails++; $display("FAIL dma_end_idle: got rd/wr/cs=%b expected 000", {rd, wr, cs}); end
    endtask

    task automatic test_restart();
        int cnt = 0;
        int bad = 0;
        clear_oam();
        for (int i = 0; i < 160; i++) ext_mem[16'hD000 + i] = 8'(i) ^ 8'h5A;
        write_dma(8'hC0);
        repeat (49) @(negedge clk);
        cpu_a = 16'hFF46; cpu_dout = 8'hD0; cpu_wr = 1'b1;
        @(negedge clk);
        cpu_idle();
        first_rd_pend = 1'b1; rd_cnt = 0;
        while (dma_active === 1'b1 && cnt < 2000) begin
            cnt++;
            @(negedge clk);
        end
        n_checks++;
        if (cnt != 641) begin n_fails++; $display("FAIL restart_duration: got %0d clocks expected 641", cnt); end
        n_checks++;
        if (first_rd_a !== 16'hD000 || rd_cnt != 320) begin
            n_fails++; $display("FAIL restart_reads: got first=%h count=%0d expected d000 320", first_rd_a, rd_cnt);
        end
        for (int i = 0; i < 160; i++) if (ext_mem[16'hFE00 + i] !== (8'(i) ^ 8'h5A)) bad++;
        n_checks++;
        if (bad != 0) begin n_fails++; $display("FAIL restart_oam_data: got %0d wrong bytes expected 0", bad); end
    endtask

    task automatic test_abort();
        int cnt = 0;
        clear_oam();
        wr_cnt = 0;
        write_dma(8'hC0);
        while (!(rd === 1'b1 && a === 16'hC014) && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        n_checks++;
        if (cnt >= 1000) begin n_fails++; $display("FAIL abort_wait: got timeout expected read of c014"); end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n_checks++;
        if (dma_active !== 1'b0) begin n_fails++; $display("FAIL abort_dma_active: got %b expected 0", dma_active); end
        repeat (20) @(negedge clk);
        n_checks++;
        if (wr_cnt != 40 || ext_mem[16'hFE14] !== 8'hEE) begin
            n_fails++; $display("FAIL abort_no_writes: got wr=%0d fe14=%h expected 40 ee", wr_cnt, ext_mem[16'hFE14]);
        end
        n_checks++;
        if ({rd, wr, cs, dma_active} !== 4'b0000) begin n_fails++; $display("FAIL abort_idle: got rd/wr/cs/act=%b expected 0000", {rd, wr, cs, dma_active}); end
        cpu_a = 16'hFF46; cpu_rd = 1'b1;
        #1;
        n_checks++;
        if (cpu_din !== 8'h00) begin n_fails++; $display("FAIL abort_dma_reg: got %h expected 00", cpu_din); end
        @(negedge clk);
        cpu_idle();
        n_checks++;
        if (cs_err != 0) begin n_fails++; $display("FAIL cs_tracks_rd_wr: got %0d bad cycles expected 0", cs_err); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ext_mem[i] = 8'(i);
        ext_mem[16'h4000] = 8'h77;
        test_reset();
        test_hram();
        test_ext();
        test_dma_default();
        test_restart();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
